// File: rtl/mxv_sequencer_if.sv
// mxv_sequencer_if
//   Connects the matrix-vector sequencer to the receive FIFO and to the result
//   consumer (UART transmit path).
//   master : the sequencer (drives fifo_pop and the result_* outputs)
//   slave  : the environment (drives the FIFO status/data and result_ready)
//   Signals:
//     fifo_empty   receive FIFO empty
//     fifo_data    FIFO head, valid the cycle after fifo_pop
//     fifo_pop     pop request, one cycle per element
//     result_valid row result available
//     result_ready downstream accepts the result
//     result_data  row dot product, unsigned
//     result_row   row index of result_data
interface mxv_sequencer_if #(
  parameter int WORD_LENGTH = 8,
  parameter int ACC_LENGTH  = 19
);
  logic                   fifo_empty;
  logic [WORD_LENGTH-1:0] fifo_data;
  logic                   fifo_pop;
  logic                   result_valid;
  logic                   result_ready;
  logic [ACC_LENGTH-1:0]  result_data;
  logic [WORD_LENGTH-1:0] result_row;

  modport master (
    input  fifo_empty, fifo_data, result_ready,
    output fifo_pop, result_valid, result_data, result_row
  );

  modport slave (
    output fifo_empty, fifo_data, result_ready,
    input  fifo_pop, result_valid, result_data, result_row
  );
endinterface

// File: rtl/mxv_sequencer.sv
// mxv_sequencer
//   Sequences an N x N matrix-vector multiply. On start the matrix is popped
//   row-major from the receive FIFO and each element is multiplied with the
//   latched vector element of its column and accumulated. Each row sum is
//   offered on a valid/ready port. This block is the only driver of fifo_pop.
//   Ports:
//     clk           system clock, rising edge
//     reset         asynchronous, active-low
//     start         1-cycle pulse, accepted only in IDLE
//     abort         synchronous cancel of the current command
//     matrix_length N, sampled with start
//     vector        element i at [i*WORD_LENGTH +: WORD_LENGTH], sampled with start
//     bus           FIFO pop side and result handshake (master modport)
//     busy          high in every state except IDLE
//     done          1-cycle pulse after the last row is accepted
//     error         sticky illegal-N flag, cleared by the next accepted start
module mxv_sequencer #(
  parameter int WORD_LENGTH = 8,
  parameter int MAX_N       = 8,
  parameter int ACC_LENGTH  = 2*WORD_LENGTH + $clog2(MAX_N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WORD_LENGTH-1:0]       matrix_length,
  input  logic [MAX_N*WORD_LENGTH-1:0] vector,
  mxv_sequencer_if.master              bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [WORD_LENGTH-1:0] MAX_N_W = WORD_LENGTH'(MAX_N);

  typedef enum logic [2:0] {IDLE, CHECK, POP, MAC, EMIT, DONE, ERR} state_t;

  state_t                       state;
  logic [WORD_LENGTH-1:0]       n_q;
  logic [MAX_N*WORD_LENGTH-1:0] vector_q;
  logic [CNT_W-1:0]             row_q;
  logic [CNT_W-1:0]             col_q;
  logic [ACC_LENGTH-1:0]        acc_q;

  logic [WORD_LENGTH-1:0]       n_last;
  logic [WORD_LENGTH-1:0]       vec_elem;
  logic [ACC_LENGTH-1:0]        acc_next;
  logic                         col_last;
  logic                         row_last;

  // Unsigned element product, zero-extended to the accumulator width.
  function automatic logic [ACC_LENGTH-1:0] mac_product(
    input logic [WORD_LENGTH-1:0] a,
    input logic [WORD_LENGTH-1:0] b
  );
    logic [2*WORD_LENGTH-1:0] p;
    p = {{WORD_LENGTH{1'b0}}, a} * {{WORD_LENGTH{1'b0}}, b};
    return ACC_LENGTH'(p);
  endfunction

  always_comb begin
    n_last   = n_q - WORD_LENGTH'(1);
    vec_elem = vector_q[int'(col_q)*WORD_LENGTH +: WORD_LENGTH];
    acc_next = acc_q + mac_product(bus.fifo_data, vec_elem);
    col_last = (WORD_LENGTH'(col_q) == n_last);
    row_last = (WORD_LENGTH'(row_q) == n_last);
  end

  // Pop is combinational so the element arrives in the following MAC cycle;
  // an abort in the same cycle suppresses it so no element is consumed for a
  // command that is being cancelled.
  assign bus.fifo_pop = (state == POP) && !bus.fifo_empty && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      n_q              <= '0;
      vector_q         <= '0;
      row_q            <= '0;
      col_q            <= '0;
      acc_q            <= '0;
      bus.result_valid <= 1'b0;
      bus.result_data  <= '0;
      bus.result_row   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Abort beats every other transition, including a result handshake.
      state            <= IDLE;
      bus.result_valid <= 1'b0;
      bus.result_data  <= '0;
      bus.result_row   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q      <= matrix_length;
            vector_q <= vector;
            error    <= 1'b0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (n_q == '0 || n_q > MAX_N_W) begin
            state <= ERR;
          end else begin
            row_q <= '0;
            col_q <= '0;
            acc_q <= '0;
            state <= POP;
          end
        end
        POP: begin
          if (!bus.fifo_empty) state <= MAC;
        end
        MAC: begin
          acc_q <= acc_next;
          if (col_last) begin
            // Load the result registers directly from the final sum so the
            // row is presented on the very first EMIT cycle.
            bus.result_valid <= 1'b1;
            bus.result_data  <= acc_next;
            bus.result_row   <= WORD_LENGTH'(row_q);
            state            <= EMIT;
          end else begin
            col_q <= col_q + CNT_W'(1);
            state <= POP;
          end
        end
        EMIT: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            if (row_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row_q <= row_q + CNT_W'(1);
              col_q <= '0;
              acc_q <= '0;
              state <= POP;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_sequencer.sv
// tb_mxv_sequencer
//   Drives mxv_sequencer with a behavioural receive FIFO and a result sink.
//   Expected row sums come from a dot-product model and are queued when the
//   command is issued; observed handshakes are queued and compared per test.
module tb_mxv_sequencer;
  localparam int WL   = 8;
  localparam int MAXN = 8;
  localparam int ACCL = 2*WL + $clog2(MAXN);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WL-1:0]    matrix_length;
  logic [MAXN*WL-1:0] vector;
  logic             busy;
  logic             done;
  logic             error;

  mxv_sequencer_if #(.WORD_LENGTH(WL), .ACC_LENGTH(ACCL)) bus ();

  mxv_sequencer #(.WORD_LENGTH(WL), .MAX_N(MAXN), .ACC_LENGTH(ACCL)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .matrix_length (matrix_length),
    .vector        (vector),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Receive FIFO model: tasks append at wr_ptr, the model pops at rd_ptr.
  logic [WL-1:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_count = 0;
  int illegal_pops = 0;
  bit stall = 1'b0;
  bit flush = 1'b0;

  always @(posedge clk) begin
    if (bus.fifo_pop) begin
      pop_count++;
      if (bus.fifo_empty !== 1'b0) illegal_pops++;
      if (rd_ptr < wr_ptr) begin
        bus.fifo_data <= fifo_mem[rd_ptr];
        rd_ptr++;
      end
    end
    if (flush) rd_ptr = wr_ptr;
    bus.fifo_empty <= (rd_ptr == wr_ptr) || stall;
  end

  int m_mat [64];
  int m_vec [8];
  logic [ACCL-1:0] exp_data [$];
  logic [WL-1:0]   exp_row  [$];
  logic [ACCL-1:0] obs_data [$];
  logic [WL-1:0]   obs_row  [$];

  task automatic clear_queues();
    exp_data.delete(); exp_row.delete(); obs_data.delete(); obs_row.delete();
  endtask

  task automatic flush_fifo();
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic load_fifo(input int n);
    for (int i = 0; i < n*n; i++) begin
      fifo_mem[wr_ptr] = WL'(m_mat[i]);
      wr_ptr++;
    end
  endtask

  task automatic push_expected(input int n);
    longint s;
    for (int r = 0; r < n; r++) begin
      s = 0;
      for (int c = 0; c < n; c++) s += longint'(m_mat[r*n+c]) * longint'(m_vec[c]);
      exp_data.push_back(ACCL'(s));
      exp_row.push_back(WL'(r));
    end
  endtask

  // Returns on the falling edge right after the edge that samples start.
  task automatic pulse_start(input int n);
    @(negedge clk);
    matrix_length = WL'(n);
    vector = '0;
    for (int i = 0; i < MAXN; i++) vector[i*WL +: WL] = WL'(m_vec[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs until busy falls, recording handshakes. first_valid counts rising
  // edges with the start-sampling edge as edge 1.
  task automatic collect(input int budget, input int stall_at, input int stall_len,
                         output int first_valid, output int dones, output bit timed_out);
    int k, base, scnt;
    bit stalled;
    k = 1; first_valid = -1; dones = 0; timed_out = 1'b0;
    base = pop_count; scnt = 0; stalled = 1'b0;
    while (1) begin
      if (bus.result_valid && first_valid < 0) first_valid = k;
      if (bus.result_valid && bus.result_ready) begin
        obs_data.push_back(bus.result_data);
        obs_row.push_back(bus.result_row);
      end
      if (done) dones++;
      if (stalled && stall) begin
        scnt++;
        if (scnt >= stall_len) stall = 1'b0;
      end
      if (stall_at >= 0 && !stalled && (pop_count - base) >= stall_at) begin
        stall = 1'b1; stalled = 1'b1; scnt = 0;
      end
      if (!busy) break;
      if (k >= budget) begin timed_out = 1'b1; break; end
      @(negedge clk);
      k++;
    end
    stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; matrix_length = '0; vector = '0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid); end
    checks++; if (bus.result_data !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", bus.result_data); end
    checks++; if (bus.result_row !== '0) begin errors++; $display("FAIL reset_row: got %0d expected 0", bus.result_row); end
    checks++; if (bus.fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", bus.fifo_pop); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int fv, dn, p0;
    bit to;
    flush_fifo(); clear_queues();
    m_mat[0] = 1; m_mat[1] = 2; m_mat[2] = 3; m_mat[3] = 4;
    m_vec[0] = 5; m_vec[1] = 6;
    for (int i = 2; i < 8; i++) m_vec[i] = 0;
    load_fifo(2); push_expected(2);
    bus.result_ready = 1'b1;
    p0 = pop_count;
    pulse_start(2);
    collect(100, -1, 0, fv, dn, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: busy still %b after budget", busy); end
    checks++; if (obs_data.size() != exp_data.size()) begin errors++; $display("FAIL basic_count: got %0d results expected %0d", obs_data.size(), exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_row[i] !== exp_row[i]) begin
        errors++; $display("FAIL basic_result%0d: got row %0d data %0d expected row %0d data %0d", i, obs_row[i], obs_data[i], exp_row[i], exp_data[i]);
      end
    end
    checks++; if (pop_count - p0 != 4) begin errors++; $display("FAIL basic_pops: got %0d expected 4", pop_count - p0); end
    checks++; if (dn != 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", dn); end
    checks++; if (fv != 6) begin errors++; $display("FAIL basic_latency: got %0d expected 6", fv); end
    checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL basic_end: got busy %b error %b expected 0 0", busy, error); end
  endtask

  task automatic test_max();
    int fv, dn, p0;
    bit to;
    flush_fifo(); clear_queues();
    for (int i = 0; i < 64; i++) m_mat[i] = 255;
    for (int i = 0; i < 8; i++) m_vec[i] = 255;
    load_fifo(8); push_expected(8);
    bus.result_ready = 1'b1;
    p0 = pop_count;
    pulse_start(8);
    collect(400, -1, 0, fv, dn, to);
    checks++; if (to) begin errors++; $display("FAIL max_timeout: busy still %b after budget", busy); end
    checks++; if (obs_data.size() != 8) begin errors++; $display("FAIL max_count: got %0d results expected 8", obs_data.size()); end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_row[i] !== exp_row[i]) begin
        errors++; $display("FAIL max_result%0d: got row %0d data %0d expected row %0d data %0d", i, obs_row[i], obs_data[i], exp_row[i], exp_data[i]);
      end
    end
    checks++; if (pop_count - p0 != 64) begin errors++; $display("FAIL max_pops: got %0d expected 64", pop_count - p0); end
    checks++; if (fv != 18) begin errors++; $display("FAIL max_latency: got %0d expected 18", fv); end
    checks++; if (dn != 1) begin errors++; $display("FAIL max_done: got %0d pulses expected 1", dn); end
  endtask

  task automatic test_backpressure();
    int fv, dn, p0, p1, k, unstable, popped;
    bit to;
    logic [ACCL-1:0] d0;
    logic [WL-1:0] r0;
    flush_fifo(); clear_queues();
    for (int i = 0; i < 9; i++) m_mat[i] = 10 + 17*i;
    m_vec[0] = 2; m_vec[1] = 7; m_vec[2] = 3;
    for (int i = 3; i < 8; i++) m_vec[i] = 0;
    load_fifo(3); push_expected(3);
    bus.result_ready = 1'b0;
    p0 = pop_count;
    pulse_start(3);
    k = 0;
    while (!bus.result_valid && k < 100) begin @(negedge clk); k++; end
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got valid %b expected 1", bus.result_valid); end
    d0 = bus.result_data; r0 = bus.result_row; p1 = pop_count;
    unstable = 0; popped = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.result_valid !== 1'b1 || bus.result_data !== d0 || bus.result_row !== r0) unstable++;
      if (bus.fifo_pop !== 1'b0) popped++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
    checks++; if (popped != 0 || pop_count != p1) begin errors++; $display("FAIL bp_no_pop: got %0d pops expected 0", pop_count - p1); end
    bus.result_ready = 1'b1;
    collect(200, -1, 0, fv, dn, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: busy still %b after budget", busy); end
    checks++; if (obs_data.size() != 3) begin errors++; $display("FAIL bp_count: got %0d results expected 3", obs_data.size()); end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_row[i] !== exp_row[i]) begin
        errors++; $display("FAIL bp_result%0d: got row %0d data %0d expected row %0d data %0d", i, obs_row[i], obs_data[i], exp_row[i], exp_data[i]);
      end
    end
    checks++; if (pop_count - p0 != 9 || dn != 1) begin errors++; $display("FAIL bp_end: got %0d pops %0d done expected 9 1", pop_count - p0, dn); end
  endtask

  task automatic test_stall();
    int fv, dn, p0, ip0;
    bit to;
    flush_fifo(); clear_queues();
    for (int i = 0; i < 9; i++) m_mat[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) m_vec[i] = int'($urandom_range(0, 255));
    for (int i = 3; i < 8; i++) m_vec[i] = 0;
    load_fifo(3); push_expected(3);
    bus.result_ready = 1'b1;
    p0 = pop_count; ip0 = illegal_pops;
    pulse_start(3);
    collect(200, 4, 5, fv, dn, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout: busy still %b after budget", busy); end
    checks++; if (illegal_pops != ip0) begin errors++; $display("FAIL stall_pop_while_empty: got %0d expected 0", illegal_pops - ip0); end
    checks++; if (obs_data.size() != 3) begin errors++; $display("FAIL stall_count: got %0d results expected 3", obs_data.size()); end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_row[i] !== exp_row[i]) begin
        errors++; $display("FAIL stall_result%0d: got row %0d data %0d expected row %0d data %0d", i, obs_row[i], obs_data[i], exp_row[i], exp_data[i]);
      end
    end
    checks++; if (pop_count - p0 != 9) begin errors++; $display("FAIL stall_pops: got %0d expected 9", pop_count - p0); end
  endtask

  task automatic test_error();
    int fv, dn, p0;
    bit to;
    int bad_n [2];
    bad_n[0] = 0; bad_n[1] = 9;
    flush_fifo();
    bus.result_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      clear_queues();
      p0 = pop_count;
      pulse_start(bad_n[t]);
      collect(20, -1, 0, fv, dn, to);
      checks++;
      if (to || error !== 1'b1 || dn != 0 || pop_count != p0 || obs_data.size() != 0) begin
        errors++; $display("FAIL error_n%0d: got error %b done %0d pops %0d results %0d expected 1 0 0 0", bad_n[t], error, dn, pop_count - p0, obs_data.size());
      end
    end
    clear_queues();
    m_mat[0] = 9; m_mat[1] = 8; m_mat[2] = 7; m_mat[3] = 6;
    m_vec[0] = 3; m_vec[1] = 4;
    load_fifo(2); push_expected(2);
    pulse_start(2);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_clear: got %b expected 0", error); end
    collect(100, -1, 0, fv, dn, to);
    checks++; if (obs_data.size() != 2 || dn != 1) begin errors++; $display("FAIL error_recover: got %0d results %0d done expected 2 1", obs_data.size(), dn); end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_row[i] !== exp_row[i]) begin
        errors++; $display("FAIL error_result%0d: got row %0d data %0d expected row %0d data %0d", i, obs_row[i], obs_data[i], exp_row[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int fv, dn, p0, k, seen;
    bit to;
    // Asynchronous reset in the middle of a row.
    flush_fifo(); clear_queues();
    for (int i = 0; i < 9; i++) m_mat[i] = i + 1;
    m_vec[0] = 1; m_vec[1] = 2; m_vec[2] = 3;
    load_fifo(3);
    bus.result_ready = 1'b1;
    p0 = pop_count;
    pulse_start(3);
    k = 0;
    while (pop_count - p0 < 2 && k < 50) begin @(negedge clk); k++; end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.result_valid !== 1'b0 || done !== 1'b0 || error !== 1'b0 || bus.fifo_pop !== 1'b0 || bus.result_data !== '0) begin
      errors++; $display("FAIL midrow_reset: got busy %b valid %b done %b error %b pop %b data %0d expected all 0", busy, bus.result_valid, done, error, bus.fifo_pop, bus.result_data);
    end
    @(negedge clk);
    reset = 1'b1;
    // Abort coinciding with a handshake on the first row result.
    flush_fifo(); clear_queues();
    m_mat[0] = 1; m_mat[1] = 2; m_mat[2] = 3; m_mat[3] = 4;
    m_vec[0] = 5; m_vec[1] = 6;
    load_fifo(2);
    bus.result_ready = 1'b0;
    pulse_start(2);
    k = 0;
    while (!bus.result_valid && k < 50) begin @(negedge clk); k++; end
    checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL abort_valid_timeout: got %b expected 1", bus.result_valid); end
    abort = 1'b1;
    bus.result_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.result_valid !== 1'b0 || done !== 1'b0 || bus.result_data !== '0 || bus.result_row !== '0) begin
      errors++; $display("FAIL abort_idle: got busy %b valid %b done %b data %0d row %0d expected all 0", busy, bus.result_valid, done, bus.result_data, bus.result_row);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || bus.result_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_stays_idle: got %0d active cycles expected 0", seen); end
    // A start pulse while busy must be ignored.
    flush_fifo(); clear_queues();
    load_fifo(2); push_expected(2);
    p0 = pop_count;
    pulse_start(2);
    @(negedge clk);
    matrix_length = WL'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(100, -1, 0, fv, dn, to);
    checks++; if (to || obs_data.size() != 2 || dn != 1 || pop_count - p0 != 4) begin
      errors++; $display("FAIL busy_start: got %0d results %0d done %0d pops expected 2 1 4", obs_data.size(), dn, pop_count - p0);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_row[i] !== exp_row[i]) begin
        errors++; $display("FAIL busy_start_result%0d: got row %0d data %0d expected row %0d data %0d", i, obs_row[i], obs_data[i], exp_row[i], exp_data[i]);
      end
    end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got busy %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_stall();
    test_error();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
